fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue MIPS core. Holds the program counter, issues in-order word requests to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs in a small FIFO. Feeds the decode/control stage with `instr`/`instr_pc` under a valid/ready handshake. Accepts the control stage's branch decision (`pc_we` plus target) as a redirect that flushes in-flight work.

---
 rtl/fetch_unit.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage for the single-issue MIPS core. Holds the program
// counter, issues in-order word requests to instruction memory, tracks the
// address of every outstanding request, and buffers returned words with
// their PCs in a DEPTH-entry FIFO that feeds decode. A redirect (taken branch)
// reloads the PC, empties the FIFO and marks every in-flight response to be
// discarded when it returns.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        FIFO entries and maximum outstanding requests (power of 2, >= 2)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req/addr/gnt            request channel to instruction memory
//   imem_rvalid/rdata            in-order response channel
//   redirect, redirect_pc        taken branch from the control stage
//   instr, instr_pc, instr_valid head of the instruction buffer
//   instr_ready                  decode consumes the head entry
//   misalign                     sticky misaligned-redirect flag
//
// Build option
//   FETCH_MISALIGN_CHECK_EN      when defined, a redirect target with nonzero
//                                low bits sets misalign (sticky until reset);
//                                otherwise misalign is tied low
//
// State (started flag)
//   started | meaning
//   0       | reset just released, no requests issued yet
//   1       | fetching
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic          started_q;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;

    // Address queue: one entry per outstanding request, in issue order.
    logic [31:0]   aq_mem_q [DEPTH];
    logic [31:0]   aq_mem_d [DEPTH];
    logic [AW-1:0] aq_wr_q, aq_wr_d;
    logic [AW-1:0] aq_rd_q, aq_rd_d;

    // Instruction buffer: word and its PC.
    logic [31:0]   fw_mem_q [DEPTH];
    logic [31:0]   fw_mem_d [DEPTH];
    logic [31:0]   fp_mem_q [DEPTH];
    logic [31:0]   fp_mem_d [DEPTH];
    logic [AW-1:0] f_wr_q, f_wr_d;
    logic [AW-1:0] f_rd_q, f_rd_d;

    logic          fire;
    logic          rsp;
    logic          push;
    logic          pop;
    logic [CW:0]   inflight;

    // Credits cover both buffered words and requests still in flight, so a
    // returning response always finds a free FIFO slot.
    assign inflight  = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req  = started_q && (inflight < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;

    assign fire = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol violation; ignore it.
    assign rsp  = imem_rvalid && (outst_q != '0);
    assign push = rsp && (drop_q == '0) && !redirect;
    assign pop  = valid_q && instr_ready && !redirect;

    assign instr       = fw_mem_q[f_rd_q];
    assign instr_pc    = fp_mem_q[f_rd_q];
    assign instr_valid = valid_q;

    always_comb begin
        pc_d     = pc_q;
        outst_d  = outst_q + CW'(fire) - CW'(rsp);
        drop_d   = drop_q;
        count_d  = count_q;
        aq_mem_d = aq_mem_q;
        aq_wr_d  = aq_wr_q;
        aq_rd_d  = aq_rd_q;
        fw_mem_d = fw_mem_q;
        fp_mem_d = fp_mem_q;
        f_wr_d   = f_wr_q;
        f_rd_d   = f_rd_q;

        if (fire) begin
            aq_mem_d[aq_wr_q] = pc_q;
            aq_wr_d           = aq_wr_q + AW'(1);
            pc_d              = pc_q + 32'd4;
        end
        if (rsp) begin
            aq_rd_d = aq_rd_q + AW'(1);
        end

        if (redirect) begin
            // A request granted this cycle still used the old PC; it is
            // already counted in outst_d and so will be dropped too.
            pc_d    = {redirect_pc[31:2], 2'b00};
            drop_d  = outst_d;
            count_d = '0;
            f_wr_d  = '0;
            f_rd_d  = '0;
        end else begin
            if (rsp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                fw_mem_d[f_wr_q] = imem_rdata;
                fp_mem_d[f_wr_q] = aq_mem_q[aq_rd_q];
                f_wr_d           = f_wr_q + AW'(1);
            end
            if (pop) begin
                f_rd_d = f_rd_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            pc_q      <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            aq_wr_q   <= '0;
            aq_rd_q   <= '0;
            f_wr_q    <= '0;
            f_rd_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                aq_mem_q[i] <= '0;
                fw_mem_q[i] <= '0;
                fp_mem_q[i] <= '0;
            end
        end else begin
            started_q <= 1'b1;
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            aq_wr_q   <= aq_wr_d;
            aq_rd_q   <= aq_rd_d;
            f_wr_q    <= f_wr_d;
            f_rd_q    <= f_rd_d;
            aq_mem_q  <= aq_mem_d;
            fw_mem_q  <= fw_mem_d;
            fp_mem_q  <= fp_mem_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q | (redirect && (redirect_pc[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign misalign      = 1'b0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && imem_rvalid && (outst_q == '0)) begin
            $display("fetch_unit: error: imem_rvalid with no outstanding request, response ignored");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic        misalign;

    logic        gnt_en = 1'b1;
    int          lat = 1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        exp_mis;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;
    rsp_t mq[$];

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    // Grant is driven raw; the DUT must qualify it with its own request.
    assign imem_gnt = gnt_en;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: decides at the falling edge what the next rising edge
    // samples. A grant at edge k returns its word at edge k+lat.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data_of(mq[0].addr);
            void'(mq.pop_front());
        end
        if (imem_req && gnt_en) begin
            mq.push_back('{imem_addr, cyc + 1 + lat});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the first edge with rst_n high.
    task automatic do_reset(input int l);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mq.delete();
        lat = l;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        // ---------------- reset values ----------------
        step();
        step();
        chk("rst_req",      {31'b0, imem_req},    32'd0);
        chk("rst_addr",     imem_addr,            RST_PC);
        chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("rst_instr",    instr,                32'd0);
        chk("rst_instr_pc", instr_pc,             32'd0);
        chk("rst_misalign", {31'b0, misalign},    32'd0);

        // ---------------- startup, 1-cycle memory ----------------
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("st_req0",  {31'b0, imem_req}, 32'd1);
        chk("st_addr0", imem_addr,         32'h100);
        step();
        chk("st_addr1",  imem_addr,            32'h104);
        chk("st_valid1", {31'b0, instr_valid}, 32'd0);
        step();
        chk("st_addr2",  imem_addr,            32'h108);
        chk("st_valid2", {31'b0, instr_valid}, 32'd1);
        chk("st_pc2",    instr_pc,             32'h100);
        chk("st_instr2", instr,                data_of(32'h100));
        for (int i = 1; i <= 2; i++) begin
            step();
            chk("st_stream_valid", {31'b0, instr_valid}, 32'd1);
            chk("st_stream_pc",    instr_pc,             32'h100 + 32'(4 * i));
        end

        // ---------------- decode stall ----------------
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc",    instr_pc,             32'h108);
            chk("stall_instr", instr,                data_of(32'h108));
        end
        chk("stall_req",  {31'b0, imem_req}, 32'd0);
        chk("stall_addr", imem_addr,         32'h118);
        chk("stall_cnt",  32'(dut.count_q),  32'd4);
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("drain_valid", {31'b0, instr_valid}, 32'd1);
            chk("drain_pc",    instr_pc,             32'h10C + 32'(4 * i));
        end

        // ---------------- redirect with 2 outstanding, 3-cycle memory ----------------
        do_reset(3);
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        gnt_en      = 1'b0;
        step();
        redirect = 1'b0;
        gnt_en   = 1'b1;
        chk("rd3_addr",  imem_addr,            32'h200);
        chk("rd3_req",   {31'b0, imem_req},    32'd1);
        chk("rd3_valid", {31'b0, instr_valid}, 32'd0);
        chk("rd3_drop",  32'(dut.drop_q),      32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd3_wait_valid", {31'b0, instr_valid}, 32'd0);
        end
        chk("rd3_drop_done", 32'(dut.drop_q), 32'd0);
        step();
        chk("rd3_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("rd3_first_pc",    instr_pc,             32'h200);
        chk("rd3_first_instr", instr,                data_of(32'h200));
        step();
        chk("rd3_second_pc", instr_pc, 32'h204);

        // ---------------- redirect coinciding with grant and response ----------------
        do_reset(1);
        step();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        chk("rdx_valid", {31'b0, instr_valid}, 32'd0);
        chk("rdx_addr",  imem_addr,            32'h400);
        chk("rdx_drop",  32'(dut.drop_q),      32'd1);
        step();
        chk("rdx_valid2", {31'b0, instr_valid}, 32'd0);
        chk("rdx_drop2",  32'(dut.drop_q),      32'd0);
        step();
        chk("rdx_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("rdx_first_pc",    instr_pc,             32'h400);
        chk("rdx_first_instr", instr,                data_of(32'h400));
        step();
        chk("rdx_second_pc", instr_pc, 32'h404);

        // ---------------- misaligned redirect ----------------
        redirect    = 1'b1;
        redirect_pc = 32'h302;
        step();
        redirect = 1'b0;
        chk("mis_flag",  {31'b0, misalign},    {31'b0, exp_mis});
        chk("mis_addr",  imem_addr,            32'h300);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("mis_valid2", {31'b0, instr_valid}, 32'd0);
        step();
        chk("mis_pc",     instr_pc,             32'h300);
        chk("mis_valid3", {31'b0, instr_valid}, 32'd1);
        chk("mis_sticky", {31'b0, misalign},    {31'b0, exp_mis});

        // ---------------- reset mid-operation ----------------
        instr_ready = 1'b0;
        do_reset(1);
        for (int i = 0; i < 4; i++) step();
        chk("mid_pre_valid", {31'b0, instr_valid}, 32'd1);
        chk("mid_pre_cnt",   32'(dut.count_q),     32'd3);
        chk("mid_pre_outst", 32'(dut.outst_q),     32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_req",      {31'b0, imem_req},    32'd0);
        chk("mid_addr",     imem_addr,            RST_PC);
        chk("mid_valid",    {31'b0, instr_valid}, 32'd0);
        chk("mid_instr",    instr,                32'd0);
        chk("mid_instr_pc", instr_pc,             32'd0);
        chk("mid_misalign", {31'b0, misalign},    32'd0);
        step();
        chk("mid_late_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_late_cnt",   32'(dut.count_q),     32'd0);
        chk("mid_late_outst", 32'(dut.outst_q),     32'd0);
        mq.delete();
        instr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("re_req",  {31'b0, imem_req}, 32'd1);
        chk("re_addr", imem_addr,         RST_PC);
        step();
        step();
        chk("re_valid", {31'b0, instr_valid}, 32'd1);
        chk("re_pc",    instr_pc,             RST_PC);
        chk("re_instr", instr,                data_of(RST_PC));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
